program_counter_stack: RTL and testbench

- Parametrised successor of the fetch-side program counter with integrated call/data stack.
- Sits between decode/ALU (flags, `result`) and instruction memory (`pc`) / register file (write port).
- Adds:
  - configurable widths and depth
  - stall
  - full/empty/depth status
  - overflow/underflow fault detection
  - single-cycle write pulses
  - full-width POP data

---
 rtl/program_counter_stack_pkg.sv | 39 +++
 rtl/program_counter_stack_if.sv | 39 +++
 rtl/program_counter_stack_lifo_stack_mem.sv | 49 ++++
 rtl/program_counter_stack.sv | 142 ++++++++++++++
 tb/tb_program_counter_stack.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/program_counter_stack_pkg.sv
// Shared types and constants for the program counter / call-data stack block.
package pcs_pkg;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_OVF      = 2'b01;
  localparam logic [1:0] FC_UNF      = 2'b10;
  localparam logic [1:0] FC_CONFLICT = 2'b11;

  typedef enum logic [2:0] {
    OP_INC,
    OP_JMP,
    OP_CALL,
    OP_RET,
    OP_PUSH,
    OP_POP,
    OP_GSA,
    OP_SWITCH
  } op_e;

  // Fixed priority: JMP > CALL > RET > PUSH > POP > GSA > SWITCH > increment
  function automatic op_e op_decode(input logic jmp, input logic call, input logic ret,
                                    input logic push, input logic pop, input logic gsa,
                                    input logic sw);
    if (jmp)       return OP_JMP;
    else if (call) return OP_CALL;
    else if (ret)  return OP_RET;
    else if (push) return OP_PUSH;
    else if (pop)  return OP_POP;
    else if (gsa)  return OP_GSA;
    else if (sw)   return OP_SWITCH;
    else           return OP_INC;
  endfunction

  // Stack pointer must represent 0..STACK_DEPTH inclusive
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/program_counter_stack_if.sv
// Decode/ALU-facing request bus and fetch/register-file-facing result bus.
interface program_counter_stack_if #(
  parameter int unsigned PC_WIDTH    = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned RADDR_WIDTH = 8,
  parameter int unsigned DEPTH_WIDTH = 11
);
  logic                   init_flag;
  logic                   stall;
  logic                   JMP_flag;
  logic                   CALL_flag;
  logic                   RET_flag;
  logic                   PUSH_flag;
  logic                   POP_flag;
  logic                   GSA_flag;
  logic                   SWITCH_flag;
  logic [DATA_WIDTH-1:0]  result;
  logic [PC_WIDTH-1:0]    pc;
  logic                   wr_en;
  logic [RADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [DEPTH_WIDTH-1:0] depth;
  logic                   full;
  logic                   empty;
  logic                   fault;
  logic [1:0]             fault_code;

  modport master (
    output init_flag, stall, JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag,
           GSA_flag, SWITCH_flag, result,
    input  pc, wr_en, wr_addr, wr_data, depth, full, empty, fault, fault_code
  );

  modport slave (
    input  init_flag, stall, JMP_flag, CALL_flag, RET_flag, PUSH_flag, POP_flag,
           GSA_flag, SWITCH_flag, result,
    output pc, wr_en, wr_addr, wr_data, depth, full, empty, fault, fault_code
  );
endinterface

// File: rtl/program_counter_stack_lifo_stack_mem.sv
// LIFO storage: one synchronous write at depth, asynchronous read at depth-1.
module lifo_stack_mem
  import pcs_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned STACK_DEPTH = 1024,
  parameter int unsigned PTR_W       = ptr_width(STACK_DEPTH)
) (
  input  logic                  clock,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic [PTR_W-1:0]      depth_o,
  output logic                  full_o,
  output logic                  empty_o
);
  localparam int unsigned ADDR_W = PTR_W - 1;
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
  localparam logic [PTR_W-1:0]  P_ONE = PTR_W'(1);

  logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];
  logic [PTR_W-1:0]      depth_q, depth_d;
  logic [ADDR_W-1:0]     wr_idx, rd_idx;

  assign wr_idx  = depth_q[ADDR_W-1:0];
  assign rd_idx  = wr_idx - A_ONE;
  assign rdata_o = mem_q[rd_idx];
  assign depth_o = depth_q;
  assign full_o  = (depth_q == PTR_W'(STACK_DEPTH));
  assign empty_o = (depth_q == '0);

  always_comb begin
    depth_d = depth_q;
    if (push_i)     depth_d = depth_q + P_ONE;
    else if (pop_i) depth_d = depth_q - P_ONE;
  end

  always_ff @(negedge clock) begin
    if (!rst_ni) depth_q <= '0;
    else         depth_q <= depth_d;
  end

  // Contents are deliberately not reset
  always_ff @(negedge clock) begin
    if (push_i) mem_q[wr_idx] <= wdata_i;
  end
endmodule

// File: rtl/program_counter_stack.sv
// Fetch-side program counter with integrated call/data stack and fault tracking.
module program_counter_stack
  import pcs_pkg::*;
#(
  parameter int unsigned      PC_WIDTH    = 16,
  parameter int unsigned      DATA_WIDTH  = 32,
  parameter int unsigned      RADDR_WIDTH = 8,
  parameter int unsigned      STACK_DEPTH = 1024,
  parameter logic [RADDR_WIDTH-1:0] SWITCH_ADDR = 8'h24,
  parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0
) (
  input logic                    clock,
  input logic                    reset_n,
  program_counter_stack_if.slave bus
);
  localparam int unsigned PTR_W = ptr_width(STACK_DEPTH);

  logic [PC_WIDTH-1:0]    pc_q, pc_d, pc_inc;
  logic                   wr_en_q, wr_en_d;
  logic [RADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
  logic                   fault_q, fault_d;
  logic [1:0]             fc_q, fc_d;

  logic                   active, multi;
  op_e                    op;
  logic                   stk_push, stk_pop, stk_full, stk_empty;
  logic [DATA_WIDTH-1:0]  stk_wdata, stk_rdata;
  logic [PTR_W-1:0]       stk_depth;

  assign active = reset_n & bus.init_flag & ~bus.stall & ~fault_q;
  assign op     = op_decode(bus.JMP_flag, bus.CALL_flag, bus.RET_flag, bus.PUSH_flag,
                            bus.POP_flag, bus.GSA_flag, bus.SWITCH_flag);
  assign multi  = $countones({bus.JMP_flag, bus.CALL_flag, bus.RET_flag, bus.PUSH_flag,
                              bus.POP_flag, bus.GSA_flag, bus.SWITCH_flag}) > 1;
  assign pc_inc = pc_q + PC_WIDTH'(1);

  always_comb begin
    pc_d      = pc_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    fault_d   = fault_q;
    fc_d      = fc_q;
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_wdata = bus.result;
    if (active) begin
      if (multi && fc_q == FC_NONE) fc_d = FC_CONFLICT;
      case (op)
        OP_JMP: pc_d = bus.result[PC_WIDTH-1:0];
        OP_CALL, OP_PUSH: begin
          if (stk_full) begin
            fault_d = 1'b1;
            fc_d    = FC_OVF;
          end else begin
            stk_push = 1'b1;
            if (op == OP_CALL) begin
              stk_wdata = DATA_WIDTH'(pc_inc);
              pc_d      = bus.result[PC_WIDTH-1:0];
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        OP_RET, OP_POP: begin
          if (stk_empty) begin
            fault_d = 1'b1;
            fc_d    = FC_UNF;
          end else begin
            stk_pop = 1'b1;
            if (op == OP_RET) begin
              pc_d = stk_rdata[PC_WIDTH-1:0];
            end else begin
              wr_en_d   = 1'b1;
              wr_addr_d = bus.result[RADDR_WIDTH-1:0];
              wr_data_d = stk_rdata;
              pc_d      = pc_inc;
            end
          end
        end
        OP_GSA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = bus.result[RADDR_WIDTH-1:0];
          wr_data_d = DATA_WIDTH'(stk_depth);
          pc_d      = pc_inc;
        end
        OP_SWITCH: begin
          wr_en_d   = 1'b1;
          wr_addr_d = SWITCH_ADDR;
          wr_data_d = DATA_WIDTH'(bus.result[0]);
          pc_d      = pc_inc;
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fault_q   <= 1'b0;
      fc_q      <= FC_NONE;
    end else begin
      pc_q      <= pc_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fault_q   <= fault_d;
      fc_q      <= fc_d;
    end
  end

  lifo_stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .STACK_DEPTH(STACK_DEPTH),
    .PTR_W      (PTR_W)
  ) u_stack (
    .clock  (clock),
    .rst_ni (reset_n),
    .push_i (stk_push),
    .pop_i  (stk_pop),
    .wdata_i(stk_wdata),
    .rdata_o(stk_rdata),
    .depth_o(stk_depth),
    .full_o (stk_full),
    .empty_o(stk_empty)
  );

  assign bus.pc         = pc_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.depth      = stk_depth;
  assign bus.full       = stk_full;
  assign bus.empty      = stk_empty;
  assign bus.fault      = fault_q;
  assign bus.fault_code = fc_q;
endmodule

// File: tb/tb_program_counter_stack.sv
// Directed self-checking bench for program_counter_stack with a 4-entry stack.
module tb_program_counter_stack;
  logic clock = 1'b1;
  logic reset_n;
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  always #5 clock = ~clock;

  program_counter_stack_if #(
    .PC_WIDTH(16), .DATA_WIDTH(32), .RADDR_WIDTH(8), .DEPTH_WIDTH(3)
  ) bus ();

  program_counter_stack #(
    .PC_WIDTH(16), .DATA_WIDTH(32), .RADDR_WIDTH(8), .STACK_DEPTH(4)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.JMP_flag = 0; bus.CALL_flag = 0; bus.RET_flag = 0; bus.PUSH_flag = 0;
    bus.POP_flag = 0; bus.GSA_flag = 0; bus.SWITCH_flag = 0;
  endtask

  // Advance one falling edge, then settle before sampling
  task automatic step();
    @(negedge clock);
    #1;
    idle();
  endtask

  task automatic do_reset();
    reset_n = 0; step(); reset_n = 1;
  endtask

  initial begin
    reset_n = 0; bus.init_flag = 1; bus.stall = 0; bus.result = '0;
    idle();
    #1;
    step();
    reset_n = 1;

    // Reset from a non-zero pc, then free-run
    bus.JMP_flag = 1; bus.result = 32'h55; step();
    chk("pc_jmp55", 32'(bus.pc), 32'h55);
    do_reset();
    chk("rst_pc", 32'(bus.pc), 32'h0);
    chk("rst_depth", 32'(bus.depth), 32'h0);
    chk("rst_wr_en", 32'(bus.wr_en), 32'h0);
    chk("rst_fault", 32'(bus.fault), 32'h0);
    chk("rst_fc", 32'(bus.fault_code), 32'h0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 32'h0);
    chk("rst_wr_data", bus.wr_data, 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_full", 32'(bus.full), 32'h0);
    step(); step(); step();
    chk("freerun_pc", 32'(bus.pc), 32'h3);

    // CALL / RET
    bus.JMP_flag = 1; bus.result = 32'h10; step();
    bus.CALL_flag = 1; bus.result = 32'h200; step();
    chk("call_pc", 32'(bus.pc), 32'h200);
    chk("call_depth", 32'(bus.depth), 32'h1);
    bus.RET_flag = 1; step();
    chk("ret_pc", 32'(bus.pc), 32'h11);
    chk("ret_depth", 32'(bus.depth), 32'h0);

    // PUSH then POP
    bus.JMP_flag = 1; bus.result = 32'h5; step();
    bus.PUSH_flag = 1; bus.result = 32'hDEADBEEF; step();
    chk("push_pc", 32'(bus.pc), 32'h6);
    chk("push_depth", 32'(bus.depth), 32'h1);
    chk("push_wr_en", 32'(bus.wr_en), 32'h0);
    bus.POP_flag = 1; bus.result = 32'h07; step();
    chk("pop_wr_en", 32'(bus.wr_en), 32'h1);
    chk("pop_wr_addr", 32'(bus.wr_addr), 32'h07);
    chk("pop_wr_data", bus.wr_data, 32'hDEADBEEF);
    chk("pop_depth", 32'(bus.depth), 32'h0);
    chk("pop_pc", 32'(bus.pc), 32'h7);
    step();
    chk("pop_wr_en_drop", 32'(bus.wr_en), 32'h0);
    chk("pop_wr_data_hold", bus.wr_data, 32'hDEADBEEF);
    chk("idle_pc", 32'(bus.pc), 32'h8);

    // Fill to full, LIFO order, then overflow
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      bus.PUSH_flag = 1; bus.result = 32'(i) * 32'h11; step();
    end
    chk("fill_depth", 32'(bus.depth), 32'h4);
    chk("fill_full", 32'(bus.full), 32'h1);
    chk("fill_pc", 32'(bus.pc), 32'h4);
    bus.POP_flag = 1; bus.result = 32'h1; step();
    chk("lifo_pop1", bus.wr_data, 32'h44);
    bus.POP_flag = 1; bus.result = 32'h2; step();
    chk("lifo_pop2", bus.wr_data, 32'h33);
    chk("lifo_depth", 32'(bus.depth), 32'h2);
    bus.PUSH_flag = 1; bus.result = 32'h55; step();
    bus.PUSH_flag = 1; bus.result = 32'h66; step();
    chk("refill_full", 32'(bus.full), 32'h1);
    chk("refill_pc", 32'(bus.pc), 32'h8);
    bus.PUSH_flag = 1; bus.result = 32'h77; step();
    chk("ovf_fault", 32'(bus.fault), 32'h1);
    chk("ovf_fc", 32'(bus.fault_code), 32'h1);
    chk("ovf_pc", 32'(bus.pc), 32'h8);
    chk("ovf_depth", 32'(bus.depth), 32'h4);
    bus.POP_flag = 1; bus.result = 32'h3; step();
    chk("halt_pc", 32'(bus.pc), 32'h8);
    chk("halt_wr_en", 32'(bus.wr_en), 32'h0);
    chk("halt_depth", 32'(bus.depth), 32'h4);
    do_reset();
    chk("recover_fault", 32'(bus.fault), 32'h0);
    chk("recover_pc", 32'(bus.pc), 32'h0);
    chk("recover_depth", 32'(bus.depth), 32'h0);

    // Underflow on RET
    step();
    bus.RET_flag = 1; step();
    chk("unf_fault", 32'(bus.fault), 32'h1);
    chk("unf_fc", 32'(bus.fault_code), 32'h2);
    chk("unf_pc", 32'(bus.pc), 32'h1);
    chk("unf_wr_en", 32'(bus.wr_en), 32'h0);
    do_reset();

    // Multi-flag conflict, SWITCH, GSA
    bus.JMP_flag = 1; bus.CALL_flag = 1; bus.result = 32'h40; step();
    chk("conf_pc", 32'(bus.pc), 32'h40);
    chk("conf_depth", 32'(bus.depth), 32'h0);
    chk("conf_fc", 32'(bus.fault_code), 32'h3);
    chk("conf_fault", 32'(bus.fault), 32'h0);
    bus.SWITCH_flag = 1; bus.result = 32'h1; step();
    chk("sw_wr_en", 32'(bus.wr_en), 32'h1);
    chk("sw_wr_addr", 32'(bus.wr_addr), 32'h24);
    chk("sw_wr_data", bus.wr_data, 32'h1);
    chk("sw_pc", 32'(bus.pc), 32'h41);
    bus.PUSH_flag = 1; bus.result = 32'hA; step();
    bus.PUSH_flag = 1; bus.result = 32'hB; step();
    bus.GSA_flag = 1; bus.result = 32'h09; step();
    chk("gsa_wr_data", bus.wr_data, 32'h2);
    chk("gsa_wr_addr", 32'(bus.wr_addr), 32'h09);
    chk("gsa_pc", 32'(bus.pc), 32'h44);

    // Stall and init_flag hold
    bus.stall = 1; bus.JMP_flag = 1; bus.result = 32'h123; step();
    chk("stall_pc", 32'(bus.pc), 32'h44);
    chk("stall_wr_en", 32'(bus.wr_en), 32'h0);
    bus.stall = 0; bus.init_flag = 0; step();
    chk("init_pc", 32'(bus.pc), 32'h44);
    bus.init_flag = 1;

    // pc wrap
    bus.JMP_flag = 1; bus.result = 32'hFFFF; step();
    chk("wrap_pre", 32'(bus.pc), 32'hFFFF);
    step();
    chk("wrap_pc", 32'(bus.pc), 32'h0);
    chk("wrap_fault", 32'(bus.fault), 32'h0);

    // Reset wins over a simultaneous op
    reset_n = 0; bus.PUSH_flag = 1; bus.result = 32'h99; step(); reset_n = 1;
    chk("rst_win_depth", 32'(bus.depth), 32'h0);
    chk("rst_win_pc", 32'(bus.pc), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
